timecode_tx: RTL and testbench
==============================

Name: timecode_tx

Overview:
- Transmit side of the minute-frame pulse time code whose receiver recovers m_bit and the second count.
- Accepts a 59-bit minute frame via a valid/ready handshake, then emits one pulse per second on tc_out.
  - A short pulse encodes 0; a long pulse encodes 1.
  - Second 59 carries no pulse; this is the minute marker.
- Sits between the local time/frame builder and the output driver.
- Supports back-to-back minutes through a one-frame holding buffer.

Parameters:
MS_DIV, 50000, clk cycles per millisecond tick (>=1)
MS_PER_SEC, 1000, millisecond ticks per second (>=3)
ZERO_MS, 100, pulse high time in ms for a 0 bit (1 <= ZERO_MS < ONE_MS)
ONE_MS, 200, pulse high time in ms for a 1 bit (ONE_MS < MS_PER_SEC)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
frame  input  59  minute frame; bit s is transmitted in second s (s = 0..58)
frame_valid  input  1  frame is presented
frame_ready  output  1  block can take a frame; a transfer occurs on valid&ready at a rising clk edge
tc_out  output  1  encoded time-code line, high = pulse
second  output  8  current second index, 0..59
m_bit  output  1  high for the whole of second 59 (minute marker)
busy  output  1  a frame is being transmitted

Behaviour:
- Reset: one clk, rst=1. Values after reset:
  - tc_out=0, second=0, m_bit=0, busy=0, frame_ready=1.
  - Pending buffer empty; dividers cleared; state IDLE.
  - rst takes priority over all other inputs, mid-frame included. Any pending frame is discarded.
- Counters:
  - div_cnt counts 0..MS_DIV-1. Its wrap is ms_tick.
  - ms_cnt counts 0..MS_PER_SEC-1 and advances on ms_tick. The wrap of ms_cnt together with ms_tick is sec_end.
  - Both counters are held at 0 in IDLE.
- frame_ready = ~pending. It depends only on register state and has no combinational path from frame_valid.
- State IDLE:
  - busy=0, tc_out=0.
  - On accept, the frame loads into the active register with no pending. In the next cycle: state SEND, second=0, busy=1, tc_out=1, counters at 0.
  - Latency from accept edge to tc_out rising is 1 clk.
- State SEND (second 0..58):
  - tc_out=1 while ms_cnt < (active[second] ? ONE_MS : ZERO_MS), else 0.
  - At sec_end, second increments. On the transition 58 -> 59, state becomes MARK.
- State MARK (second 59): m_bit=1, tc_out=0 for the whole second. At sec_end:
  - pending=1: active<=pending frame, pending<=0, second<=0, state SEND, m_bit<=0. tc_out rises in that cycle, with no idle gap.
  - pending=0 and accept in the same cycle: the accepted frame loads directly into active with the same timing as above. This is seamless continuation.
  - Otherwise: state IDLE, second<=0, m_bit<=0, busy<=0.
- Accept in SEND/MARK (outside the sec_end case above) stores the frame in pending.
  - frame_ready falls the next cycle and stays low until pending is consumed.
  - frame_valid while frame_ready=0 is ignored. No overwrite, no error.
- second never exceeds 59. m_bit and second=59 are always asserted together.
- Outputs tc_out, second, m_bit, busy and frame_ready are all registered.

Test Plan:
- Parameters for all scenarios: MS_DIV=1, MS_PER_SEC=10, ZERO_MS=1, ONE_MS=3.
- Reset then idle, frame_valid=0 for 50 clk -> tc_out=0, second=0, m_bit=0, busy=0, frame_ready=1 throughout.
- Accept frame 59'h0 in IDLE -> tc_out high 1 clk, low 9 clk for each of seconds 0..58. Second 59: tc_out low 10 clk, m_bit=1. Then IDLE, busy=0, 600 clk after start.
- Accept frame with only bit 0 and bit 58 set -> second 0 and second 58 pulses 3 clk; all other seconds 1 clk. second increments every 10 clk.
- Second frame 59'h1 presented during second 10 of the first -> frame_ready drops next clk. At the first frame's sec_end in second 59: second=0, m_bit=0, tc_out=1 the same clk; first pulse 3 clk; frame_ready returns to 1. A third valid frame during the low-ready window is not accepted.
- frame_valid held with pending empty exactly at the MARK sec_end -> direct continuation with no gap; frame_ready stays 1.
- rst asserted mid-second 30 with a pending frame -> next clk all outputs at reset values. The pending frame is dropped; nothing is transmitted until a new accept.

Source files
------------

// File: rtl/timecode_tx.sv
// Minute-frame pulse time-code transmitter: one pulse per second (short=0, long=1),
// no pulse in second 59, with a one-frame holding buffer for back-to-back minutes.
module timecode_tx #(
  parameter int unsigned MS_DIV     = 50000,
  parameter int unsigned MS_PER_SEC = 1000,
  parameter int unsigned ZERO_MS    = 100,
  parameter int unsigned ONE_MS     = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [58:0] frame,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        tc_out,
  output logic [7:0]  second,
  output logic        m_bit,
  output logic        busy
);

  localparam int unsigned DIV_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned MS_W    = $clog2(MS_PER_SEC);
  localparam int unsigned SEC_W   = 8;
  localparam int unsigned FRAME_W = 59;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MS_DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_PER_SEC - 1);
  localparam logic [MS_W-1:0]  ZERO_T   = MS_W'(ZERO_MS);
  localparam logic [MS_W-1:0]  ONE_T    = MS_W'(ONE_MS);
  localparam logic [SEC_W-1:0] LAST_BIT = SEC_W'(58);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_MARK} state_t;

  state_t             r_state, w_nxt_state;
  logic [DIV_W-1:0]   r_div_cnt, w_nxt_div, w_adv_div;
  logic [MS_W-1:0]    r_ms_cnt, w_nxt_ms, w_adv_ms;
  logic [SEC_W-1:0]   r_second, w_nxt_sec;
  logic [FRAME_W-1:0] r_active, w_nxt_active;
  logic [FRAME_W-1:0] r_pending, w_nxt_pending;
  logic               r_pend_vld, w_nxt_pend_vld;
  logic               r_tc_out, r_m_bit, r_busy, r_frame_ready;
  logic               w_accept, w_ms_tick, w_sec_end, w_bit, w_nxt_tc;
  logic [63:0]        w_bits;
  logic [MS_W-1:0]    w_thresh;

  assign w_accept  = frame_valid & r_frame_ready;
  assign w_ms_tick = (r_div_cnt == DIV_LAST);
  assign w_sec_end = w_ms_tick && (r_ms_cnt == MS_LAST);
  assign w_adv_div = w_ms_tick ? '0 : r_div_cnt + DIV_W'(1);
  assign w_adv_ms  = !w_ms_tick ? r_ms_cnt :
                     (r_ms_cnt == MS_LAST) ? '0 : r_ms_cnt + MS_W'(1);

  // Next-state logic; outputs are then derived from the next-state values so they register in step.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_div      = r_div_cnt;
    w_nxt_ms       = r_ms_cnt;
    w_nxt_sec      = r_second;
    w_nxt_active   = r_active;
    w_nxt_pending  = r_pending;
    w_nxt_pend_vld = r_pend_vld;
    case (r_state)
      S_IDLE: begin
        w_nxt_div = '0;
        w_nxt_ms  = '0;
        w_nxt_sec = '0;
        if (w_accept) begin
          w_nxt_active = frame;
          w_nxt_state  = S_SEND;
        end
      end
      S_SEND: begin
        w_nxt_div = w_adv_div;
        w_nxt_ms  = w_adv_ms;
        if (w_sec_end) begin
          w_nxt_sec = r_second + SEC_W'(1);
          if (r_second == LAST_BIT) w_nxt_state = S_MARK;
        end
        if (w_accept) begin
          w_nxt_pending  = frame;
          w_nxt_pend_vld = 1'b1;
        end
      end
      S_MARK: begin
        w_nxt_div = w_adv_div;
        w_nxt_ms  = w_adv_ms;
        if (w_sec_end) begin
          w_nxt_sec = '0;
          if (r_pend_vld) begin
            w_nxt_active   = r_pending;
            w_nxt_pend_vld = 1'b0;
            w_nxt_state    = S_SEND;
          end else if (w_accept) begin
            w_nxt_active = frame;
            w_nxt_state  = S_SEND;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end else if (w_accept) begin
          w_nxt_pending  = frame;
          w_nxt_pend_vld = 1'b1;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_div   = '0;
        w_nxt_ms    = '0;
        w_nxt_sec   = '0;
      end
    endcase
    w_bits   = 64'(w_nxt_active);
    w_bit    = w_bits[w_nxt_sec[5:0]];
    w_thresh = w_bit ? ONE_T : ZERO_T;
    w_nxt_tc = (w_nxt_state == S_SEND) && (w_nxt_ms < w_thresh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_div_cnt     <= '0;
      r_ms_cnt      <= '0;
      r_second      <= '0;
      r_active      <= '0;
      r_pending     <= '0;
      r_pend_vld    <= 1'b0;
      r_tc_out      <= 1'b0;
      r_m_bit       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_ready <= 1'b1;
    end else begin
      r_state       <= w_nxt_state;
      r_div_cnt     <= w_nxt_div;
      r_ms_cnt      <= w_nxt_ms;
      r_second      <= w_nxt_sec;
      r_active      <= w_nxt_active;
      r_pending     <= w_nxt_pending;
      r_pend_vld    <= w_nxt_pend_vld;
      r_tc_out      <= w_nxt_tc;
      r_m_bit       <= (w_nxt_state == S_MARK);
      r_busy        <= (w_nxt_state != S_IDLE);
      r_frame_ready <= ~w_nxt_pend_vld;
    end
  end

  assign frame_ready = r_frame_ready;
  assign tc_out      = r_tc_out;
  assign second      = r_second;
  assign m_bit       = r_m_bit;
  assign busy        = r_busy;

endmodule

// File: tb/tb_timecode_tx.sv
// Bench for timecode_tx: vector table, directed minute-boundary sequences and random traffic,
// all checked against a frame-time reference model.
module tb_timecode_tx;

  localparam int unsigned MS_DIV     = 1;
  localparam int unsigned MS_PER_SEC = 10;
  localparam int unsigned ZERO_MS    = 1;
  localparam int unsigned ONE_MS     = 3;
  localparam int SEC_CLK   = MS_DIV * MS_PER_SEC;
  localparam int FRAME_CLK = 60 * SEC_CLK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [58:0] frame = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready, tc_out, m_bit, busy;
  logic [7:0]  second;

  always #5 clk = ~clk;

  timecode_tx #(
    .MS_DIV(MS_DIV), .MS_PER_SEC(MS_PER_SEC), .ZERO_MS(ZERO_MS), .ONE_MS(ONE_MS)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .tc_out(tc_out), .second(second),
    .m_bit(m_bit), .busy(busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: frame-relative time m_t in clk cycles plus a one-deep pending slot.
  bit          m_act = 1'b0;
  bit          m_pv  = 1'b0;
  logic [58:0] m_cur = '0;
  logic [58:0] m_pend = '0;
  int          m_t = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    if (rst) begin
      m_act = 1'b0; m_pv = 1'b0; m_t = 0;
    end else begin
      acc = frame_valid && !m_pv;
      if (!m_act) begin
        if (acc) begin m_act = 1'b1; m_cur = frame; m_t = 0; end
      end else if (m_t == FRAME_CLK - 1) begin
        if (m_pv) begin m_cur = m_pend; m_pv = 1'b0; m_t = 0; end
        else if (acc) begin m_cur = frame; m_t = 0; end
        else begin m_act = 1'b0; m_t = 0; end
      end else begin
        m_t++;
        if (acc) begin m_pend = frame; m_pv = 1'b1; end
      end
    end
  endtask

  task automatic tick();
    int  sec, ms, width;
    bit  e_tc;
    @(posedge clk);
    model_step();
    #1;
    sec = m_act ? m_t / SEC_CLK : 0;
    ms  = (m_t % SEC_CLK) / MS_DIV;
    e_tc = 1'b0;
    if (m_act && sec < 59) begin
      width = m_cur[sec] ? ONE_MS : ZERO_MS;
      e_tc  = (ms < width);
    end
    chk("tc_out", 64'(tc_out), 64'(e_tc));
    chk("second", 64'(second), 64'(sec));
    chk("m_bit", 64'(m_bit), 64'(m_act && sec == 59));
    chk("busy", 64'(busy), 64'(m_act));
    chk("frame_ready", 64'(frame_ready), 64'(!m_pv));
  endtask

  task automatic run(input int n);
    frame_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic accept(input logic [58:0] f);
    frame = f; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic [58:0] frame;
    logic        e_tc;
    logic [7:0]  e_sec;
    logic        e_m;
    logic        e_busy;
    logic        e_rdy;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 1'b0, 59'h0,   1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b0, 59'h0,   1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 59'h1,   1'b1, 8'd0, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b0, 59'h0,   1'b1, 8'd0, 1'b0, 1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b0, 59'h0,   1'b1, 8'd0, 1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b0, 59'h0,   1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b1, 59'h2A,  1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
    vt[7] = '{1'b0, 1'b1, 59'h155, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
    vt[8] = '{1'b1, 1'b0, 59'h0,   1'b0, 8'd0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; frame_valid = vt[i].valid; frame = vt[i].frame;
      tick();
      chk("vec_tc", 64'(tc_out), 64'(vt[i].e_tc));
      chk("vec_second", 64'(second), 64'(vt[i].e_sec));
      chk("vec_m_bit", 64'(m_bit), 64'(vt[i].e_m));
      chk("vec_busy", 64'(busy), 64'(vt[i].e_busy));
      chk("vec_ready", 64'(frame_ready), 64'(vt[i].e_rdy));
    end
    rst = 1'b0;

    // Idle after reset
    run(50);

    // All-zero frame: full minute then back to idle
    accept(59'h0);
    run(FRAME_CLK - 1);
    chk("zero_mark_m_bit", 64'(m_bit), 64'd1);
    chk("zero_mark_second", 64'(second), 64'd59);
    tick();
    chk("zero_end_busy", 64'(busy), 64'd0);
    run(5);

    // Long pulses in seconds 0 and 58
    accept(59'h400_0000_0000_0001);
    run(FRAME_CLK + 5);

    // Pending frame taken at the minute marker, third frame refused
    accept(59'h0);
    run(100);
    accept(59'h1);
    chk("pend_ready_low", 64'(frame_ready), 64'd0);
    accept(59'h7FF_FFFF_FFFF_FFFF);
    run(FRAME_CLK - 1 - 102);
    chk("pend_mark_second", 64'(second), 64'd59);
    tick();
    chk("pend_cont_second", 64'(second), 64'd0);
    chk("pend_cont_m_bit", 64'(m_bit), 64'd0);
    chk("pend_cont_tc", 64'(tc_out), 64'd1);
    chk("pend_cont_ready", 64'(frame_ready), 64'd1);
    run(FRAME_CLK + 5);

    // Direct continuation: accept exactly at the marker's last cycle
    accept(59'h0);
    run(FRAME_CLK - 1);
    accept(59'h1);
    chk("direct_second", 64'(second), 64'd0);
    chk("direct_tc", 64'(tc_out), 64'd1);
    chk("direct_busy", 64'(busy), 64'd1);
    chk("direct_ready", 64'(frame_ready), 64'd1);
    run(FRAME_CLK + 5);

    // Reset mid-frame with a pending frame
    accept(59'h5555);
    run(305);
    accept(59'h3);
    rst = 1'b1;
    tick();
    chk("rst_tc", 64'(tc_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(frame_ready), 64'd1);
    chk("rst_second", 64'(second), 64'd0);
    rst = 1'b0;
    run(5 * SEC_CLK);
    chk("rst_dropped_busy", 64'(busy), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      rst         = ($urandom_range(0, 1499) == 0);
      frame_valid = ($urandom_range(0, 7) == 0);
      frame       = 59'({$urandom(), $urandom()});
      tick();
    end
    rst = 1'b0; frame_valid = 1'b0;
    run(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
